param_fifo: RTL and testbench
=============================

PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 Parameter WIDTH, default 9, data word width in bits (1..32).
REQ-002 Parameter DEPTH, default 16, number of entries; power of two, 4..256.
REQ-003 Parameter AF_LEVEL, default DEPTH-2, AlmostFull asserts when Count >= AF_LEVEL.
REQ-004 Parameter AE_LEVEL, default 2, AlmostEmpty asserts when Count <= AE_LEVEL.
REQ-005 Clock  input  1  single clock; all state changes on rising edge.
REQ-006 Reset  input  1  asynchronous, active-low reset.
REQ-007 DataIn  input  WIDTH  write data.
REQ-008 Write  input  1  active-low write request, sampled at rising Clock.
REQ-009 Read  input  1  active-low read request, sampled at rising Clock.
REQ-010 ClearOV  input  1  active-low clear of the sticky OV and UF flags.
REQ-011 DataOut  output  WIDTH  registered read data.
REQ-012 Count  output  log2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-013 Full, Empty, AlmostFull, AlmostEmpty  output  1 each  occupancy status.
REQ-014 OV  output  1  sticky overflow flag (write attempted while full).
REQ-015 UF  output  1  sticky underflow flag (read attempted while empty).

Function
REQ-016 Full = (Count == DEPTH); Empty = (Count == 0); AlmostFull/AlmostEmpty per REQ-003/004; all four combinational from Count only.
REQ-017 Accepted write: mem[WritePtr] <= DataIn, WritePtr increments modulo DEPTH.
REQ-018 Accepted read: DataOut <= mem[ReadPtr] at the same edge (one-cycle latency), ReadPtr increments modulo DEPTH.
REQ-019 DataOut holds its value in every cycle without an accepted read.
REQ-020 Read only, not Empty: accepted, Count decrements by 1.
REQ-021 Write only, not Full: accepted, Count increments by 1.
REQ-022 Read and Write, 0 < Count < DEPTH: both accepted, Count unchanged.
REQ-023 Read and Write while Full: both accepted (read frees the slot), Count stays DEPTH, OV not set.
REQ-024 Read and Write while Empty: write accepted, read ignored, Count becomes 1, DataOut unchanged, UF set.
REQ-025 Write while Full without Read: data dropped, pointers and Count unchanged, OV set.
REQ-026 Read while Empty without Write: ignored, DataOut unchanged, UF set.
REQ-027 ClearOV low clears OV and UF; a new overflow/underflow in the same cycle wins (flag stays 1).
REQ-028 OV and UF never alter Count, pointers or stored data.
REQ-029 Count arithmetic uses log2(DEPTH)+1 bits; never exceeds DEPTH nor goes below 0.

Reset
REQ-030 Reset low forces ReadPtr, WritePtr, Count, DataOut, OV and UF to 0 immediately, regardless of Clock.
REQ-031 After reset Empty = 1, AlmostEmpty = 1, Full = 0, AlmostFull = 0.
REQ-032 Storage array is not reset; contents are don't-care after reset.
REQ-033 Reset asserted mid-transfer discards that cycle's read/write; first operation honoured is at the first rising edge with Reset high.

Structure
REQ-034 Shared package fifo_pkg holds default WIDTH/DEPTH constants and the clog2 function used to size pointers and Count.
REQ-035 Storage is sub-module fifo_ram: DEPTH x WIDTH, synchronous write port, asynchronous read port, no reset.
REQ-036 Pointer, Count, flag and output-register logic reside in param_fifo.

Verification (WIDTH=9, DEPTH=16, AF_LEVEL=14, AE_LEVEL=2)
REQ-037 Reset, write 0x001..0x010 -> Count 16, Full=1, AlmostFull=1 from 14th write, OV=0; then read 16 -> DataOut 0x001..0x010 in order, Empty=1.
REQ-038 Full, write 0x1FF without read -> OV=1, Count 16; read 16 -> 0x1FF never appears; pulse ClearOV -> OV=0.
REQ-039 Count=5, hold Read and Write low 20 cycles with incrementing DataIn -> Count stays 5, output order preserved across pointer wrap.
REQ-040 Empty, Read and Write low with DataIn 0x0AA -> Count 1, UF=1, DataOut unchanged; next read -> DataOut 0x0AA.
REQ-041 Count 8, assert Reset between edges -> Count 0, DataOut 0, Empty=1 immediately; subsequent write/read returns new data only.
REQ-042 ClearOV low in the same cycle as write-while-full -> OV remains 1.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and sizing helper for the parameterised FIFO and its storage.
package fifo_pkg;

  localparam int DEF_WIDTH = 9;
  localparam int DEF_DEPTH = 16;

  // Number of address bits needed to index `value` entries (ceil(log2(value))).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// FIFO storage: DEPTH x WIDTH, synchronous write port, asynchronous read port.
// The array is intentionally not reset.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     Clock,
  input  logic                     WriteEn,
  input  logic [clog2(DEPTH)-1:0]  WriteAddr,
  input  logic [WIDTH-1:0]         WriteData,
  input  logic [clog2(DEPTH)-1:0]  ReadAddr,
  output logic [WIDTH-1:0]         ReadData
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Store the incoming word on an accepted write.
  always_ff @(posedge Clock) begin
    if (WriteEn) mem[WriteAddr] <= WriteData;
  end

  assign ReadData = mem[ReadAddr];

endmodule

// File: rtl/param_fifo.sv
// Single-clock FIFO with active-low request strobes, registered read data,
// occupancy status and sticky overflow/underflow flags.
module param_fifo
  import fifo_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic [WIDTH-1:0]        DataIn,
  input  logic                    Write,
  input  logic                    Read,
  input  logic                    ClearOV,
  output logic [WIDTH-1:0]        DataOut,
  output logic [clog2(DEPTH):0]   Count,
  output logic                    Full,
  output logic                    Empty,
  output logic                    AlmostFull,
  output logic                    AlmostEmpty,
  output logic                    OV,
  output logic                    UF
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);

  logic [AW-1:0]    writePtr;
  logic [AW-1:0]    readPtr;
  logic [WIDTH-1:0] ramData;
  logic             wrReq;
  logic             rdReq;
  logic             wrAcc;
  logic             rdAcc;
  logic             ovSet;
  logic             ufSet;

  // Status flags depend only on the occupancy count.
  assign Full        = (Count == FULL_CNT);
  assign Empty       = (Count == '0);
  assign AlmostFull  = (Count >= AF_CNT);
  assign AlmostEmpty = (Count <= AE_CNT);

  // Accept/reject decisions: a read while full frees the slot for a
  // simultaneous write; a read while empty is never accepted.
  always_comb begin
    wrReq = ~Write;
    rdReq = ~Read;
    wrAcc = wrReq & (~Full | rdReq);
    rdAcc = rdReq & ~Empty;
    ovSet = wrReq & Full & ~rdReq;
    ufSet = rdReq & Empty;
  end

  fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .Clock     (Clock),
    .WriteEn   (wrAcc),
    .WriteAddr (writePtr),
    .WriteData (DataIn),
    .ReadAddr  (readPtr),
    .ReadData  (ramData)
  );

  // Pointers wrap naturally because DEPTH is a power of two; Count tracks
  // the net effect of accepted reads and writes.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      writePtr <= '0;
      readPtr  <= '0;
      Count    <= '0;
    end else begin
      if (wrAcc) writePtr <= writePtr + AW'(1);
      if (rdAcc) readPtr  <= readPtr + AW'(1);
      case ({wrAcc, rdAcc})
        2'b10:   Count <= Count + CW'(1);
        2'b01:   Count <= Count - CW'(1);
        default: Count <= Count;
      endcase
    end
  end

  // Registered read data; holds its value unless a read is accepted.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      DataOut <= '0;
    end else if (rdAcc) begin
      DataOut <= ramData;
    end
  end

  // Sticky error flags; a fresh error in the clearing cycle keeps the flag set.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      OV <= 1'b0;
      UF <= 1'b0;
    end else begin
      OV <= ovSet | (OV & ClearOV);
      UF <= ufSet | (UF & ClearOV);
    end
  end

endmodule

// File: tb/tb_param_fifo.sv
// Directed bench for param_fifo (WIDTH=9, DEPTH=16, AF_LEVEL=14, AE_LEVEL=2).
module tb_param_fifo;

  logic       Clock;
  logic       Reset;
  logic [8:0] DataIn;
  logic       Write;
  logic       Read;
  logic       ClearOV;
  logic [8:0] DataOut;
  logic [4:0] Count;
  logic       Full;
  logic       Empty;
  logic       AlmostFull;
  logic       AlmostEmpty;
  logic       OV;
  logic       UF;

  int passCnt = 0;
  int totalCnt = 0;

  param_fifo #(
    .WIDTH    (9),
    .DEPTH    (16),
    .AF_LEVEL (14),
    .AE_LEVEL (2)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .DataIn      (DataIn),
    .Write       (Write),
    .Read        (Read),
    .ClearOV     (ClearOV),
    .DataOut     (DataOut),
    .Count       (Count),
    .Full        (Full),
    .Empty       (Empty),
    .AlmostFull  (AlmostFull),
    .AlmostEmpty (AlmostEmpty),
    .OV          (OV),
    .UF          (UF)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    bit         wr;
    bit         rd;
    bit         clr;
    logic [8:0] din;
    int         cnt;
    logic [8:0] dout;
    bit         full;
    bit         empty;
    bit         af;
    bit         ae;
    bit         ov;
    bit         uf;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string nm, input int act, input int exp);
    totalCnt++;
    if (act == exp) passCnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  // One clock cycle with the given (active-high here) requests; sampled 1ns after the edge.
  task automatic cyc(input bit wr, input bit rd, input bit clr, input logic [8:0] d);
    Write   = !wr;
    Read    = !rd;
    ClearOV = !clr;
    DataIn  = d;
    @(posedge Clock);
    #1;
    Write   = 1'b1;
    Read    = 1'b1;
    ClearOV = 1'b1;
  endtask

  initial begin
    logic [8:0] q[$];
    logic [8:0] e;

    //            wr rd clr din     cnt dout    F  E  AF AE OV UF
    vecs[0]  = '{1, 0, 0, 9'h011, 1, 9'h000, 0, 0, 0, 1, 0, 0};
    vecs[1]  = '{1, 0, 0, 9'h022, 2, 9'h000, 0, 0, 0, 1, 0, 0};
    vecs[2]  = '{1, 0, 0, 9'h033, 3, 9'h000, 0, 0, 0, 0, 0, 0};
    vecs[3]  = '{0, 1, 0, 9'h000, 2, 9'h011, 0, 0, 0, 1, 0, 0};
    vecs[4]  = '{1, 1, 0, 9'h044, 2, 9'h022, 0, 0, 0, 1, 0, 0};
    vecs[5]  = '{0, 0, 0, 9'h000, 2, 9'h022, 0, 0, 0, 1, 0, 0};
    vecs[6]  = '{0, 1, 0, 9'h000, 1, 9'h033, 0, 0, 0, 1, 0, 0};
    vecs[7]  = '{0, 1, 0, 9'h000, 0, 9'h044, 0, 1, 0, 1, 0, 0};
    vecs[8]  = '{0, 1, 0, 9'h000, 0, 9'h044, 0, 1, 0, 1, 0, 1};
    vecs[9]  = '{0, 0, 1, 9'h000, 0, 9'h044, 0, 1, 0, 1, 0, 0};
    vecs[10] = '{1, 1, 0, 9'h0AA, 1, 9'h044, 0, 0, 0, 1, 0, 1};
    vecs[11] = '{0, 1, 0, 9'h000, 0, 9'h0AA, 0, 1, 0, 1, 0, 1};
    vecs[12] = '{0, 0, 1, 9'h000, 0, 9'h0AA, 0, 1, 0, 1, 0, 0};
    vecs[13] = '{0, 1, 1, 9'h000, 0, 9'h0AA, 0, 1, 0, 1, 0, 1};
    vecs[14] = '{0, 0, 1, 9'h000, 0, 9'h0AA, 0, 1, 0, 1, 0, 0};

    Reset   = 1'b1;
    Write   = 1'b1;
    Read    = 1'b1;
    ClearOV = 1'b1;
    DataIn  = '0;

    // Reset state, observed before any clock edge
    #2 Reset = 1'b0;
    #1;
    chk("rst.count", int'(Count), 0);
    chk("rst.dout", int'(DataOut), 0);
    chk("rst.empty", int'(Empty), 1);
    chk("rst.ae", int'(AlmostEmpty), 1);
    chk("rst.full", int'(Full), 0);
    chk("rst.af", int'(AlmostFull), 0);
    chk("rst.ov", int'(OV), 0);
    chk("rst.uf", int'(UF), 0);
    @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < 15; i++) begin
      cyc(vecs[i].wr, vecs[i].rd, vecs[i].clr, vecs[i].din);
      chk($sformatf("vec%0d.count", i), int'(Count), vecs[i].cnt);
      chk($sformatf("vec%0d.dout", i), int'(DataOut), int'(vecs[i].dout));
      chk($sformatf("vec%0d.full", i), int'(Full), int'(vecs[i].full));
      chk($sformatf("vec%0d.empty", i), int'(Empty), int'(vecs[i].empty));
      chk($sformatf("vec%0d.af", i), int'(AlmostFull), int'(vecs[i].af));
      chk($sformatf("vec%0d.ae", i), int'(AlmostEmpty), int'(vecs[i].ae));
      chk($sformatf("vec%0d.ov", i), int'(OV), int'(vecs[i].ov));
      chk($sformatf("vec%0d.uf", i), int'(UF), int'(vecs[i].uf));
    end

    // Fill to full and drain in order
    for (int k = 1; k <= 16; k++) begin
      cyc(1, 0, 0, 9'(k));
      chk($sformatf("fill%0d.count", k), int'(Count), k);
      chk($sformatf("fill%0d.af", k), int'(AlmostFull), (k >= 14) ? 1 : 0);
      chk($sformatf("fill%0d.full", k), int'(Full), (k == 16) ? 1 : 0);
      chk($sformatf("fill%0d.ov", k), int'(OV), 0);
    end
    for (int k = 1; k <= 16; k++) begin
      cyc(0, 1, 0, 9'h000);
      chk($sformatf("drain%0d.dout", k), int'(DataOut), k);
      chk($sformatf("drain%0d.count", k), int'(Count), 16 - k);
    end
    chk("drain.empty", int'(Empty), 1);

    // Full: simultaneous read/write, then overflow attempts
    for (int k = 1; k <= 16; k++) cyc(1, 0, 0, 9'(k));
    cyc(1, 1, 0, 9'h100);
    chk("fullrw.dout", int'(DataOut), 1);
    chk("fullrw.count", int'(Count), 16);
    chk("fullrw.ov", int'(OV), 0);
    cyc(1, 0, 0, 9'h1FF);
    chk("ovf.ov", int'(OV), 1);
    chk("ovf.count", int'(Count), 16);
    chk("ovf.full", int'(Full), 1);
    cyc(1, 0, 1, 9'h1FF);
    chk("ovfclr.ov", int'(OV), 1);
    chk("ovfclr.count", int'(Count), 16);
    for (int k = 1; k <= 16; k++) begin
      cyc(0, 1, 0, 9'h000);
      chk($sformatf("ovdrain%0d.dout", k), int'(DataOut), (k == 16) ? 'h100 : k + 1);
    end
    chk("ovdrain.empty", int'(Empty), 1);
    chk("ovdrain.ov", int'(OV), 1);
    cyc(0, 0, 1, 9'h000);
    chk("ovclr.ov", int'(OV), 0);
    chk("ovclr.uf", int'(UF), 0);

    // Steady occupancy of 5 with simultaneous read/write across pointer wrap
    q.delete();
    for (int k = 0; k < 5; k++) begin
      cyc(1, 0, 0, 9'(9'h050 + k));
      q.push_back(9'(9'h050 + k));
    end
    chk("steady.count0", int'(Count), 5);
    for (int k = 0; k < 20; k++) begin
      cyc(1, 1, 0, 9'(9'h060 + k));
      e = q.pop_front();
      q.push_back(9'(9'h060 + k));
      chk($sformatf("steady%0d.dout", k), int'(DataOut), int'(e));
      chk($sformatf("steady%0d.count", k), int'(Count), 5);
    end
    for (int k = 0; k < 5; k++) begin
      cyc(0, 1, 0, 9'h000);
      e = q.pop_front();
      chk($sformatf("sdrain%0d.dout", k), int'(DataOut), int'(e));
    end
    chk("sdrain.empty", int'(Empty), 1);

    // Asynchronous reset in mid-cycle with 8 entries held
    for (int k = 0; k < 8; k++) cyc(1, 0, 0, 9'(9'h0C0 + k));
    chk("pre.count", int'(Count), 8);
    cyc(0, 1, 0, 9'h000);
    chk("pre.dout", int'(DataOut), 'h0C0);
    #3 Reset = 1'b0;
    #1;
    chk("arst.count", int'(Count), 0);
    chk("arst.dout", int'(DataOut), 0);
    chk("arst.empty", int'(Empty), 1);
    Write  = 1'b0;
    DataIn = 9'h155;
    @(posedge Clock);
    #1;
    chk("arst.hold", int'(Count), 0);
    @(negedge Clock);
    Write = 1'b1;
    Reset = 1'b1;
    cyc(1, 0, 0, 9'h123);
    chk("post.count", int'(Count), 1);
    cyc(0, 1, 0, 9'h000);
    chk("post.dout", int'(DataOut), 'h123);
    chk("post.empty", int'(Empty), 1);
    cyc(0, 1, 0, 9'h000);
    chk("post.hold", int'(DataOut), 'h123);
    chk("post.uf", int'(UF), 1);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
